// File: rtl/regfile_write_arbiter_pkg.sv
// Shared core constants for the register file and its writeback arbiter,
// plus the grant selector used by the arbiter.
package regfile_write_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  // Which holding slot (if any) drives the write port this cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_REQ0 = 2'd1,
    GRANT_REQ1 = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_slot.sv
// One-entry writeback holding slot: captures a request, holds it while
// stalled, and tracks whether it is younger than the other slot.
module regfile_wb_slot
  import regfile_write_arbiter_pkg::*;
#(
  parameter int XLEN       = regfile_write_arbiter_pkg::XLEN,
  parameter int REG_ADDR_W = regfile_write_arbiter_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_reg,
  input  logic [XLEN-1:0]       in_data,
  input  logic                  grant,
  input  logic                  other_remains,
  input  logic                  other_fill,
  output logic                  ready,
  output logic                  fill,
  output logic                  valid,
  output logic [REG_ADDR_W-1:0] slot_reg,
  output logic [XLEN-1:0]       slot_data,
  output logic                  age
);

  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] reg_q, reg_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic                  age_q, age_d;

  // Accept/refill decision and next slot contents; x0 writes are accepted
  // but never stored. age=1 means this entry arrived after the other one.
  always_comb begin
    ready  = reset_n && (!valid_q || grant);
    fill   = in_valid && ready && (in_reg != '0);
    valid_d = valid_q;
    reg_d   = reg_q;
    data_d  = data_q;
    age_d   = age_q;
    if (fill) begin
      valid_d = 1'b1;
      reg_d   = in_reg;
      data_d  = in_data;
    end else if (grant) begin
      valid_d = 1'b0;
    end
    if (fill) begin
      age_d = other_remains;
    end else if (!valid_d) begin
      age_d = 1'b0;
    end else if (other_fill) begin
      age_d = 1'b0;
    end
  end

  // Slot state register, cleared immediately on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
      age_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      age_q   <= age_d;
    end
  end

  assign valid     = valid_q;
  assign slot_reg  = reg_q;
  assign slot_data = data_q;
  assign age       = age_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester register file write arbiter: oldest slot wins, simultaneous
// arrivals resolved round-robin (same-destination ties favour requester 0 so
// requester 1's value lands last), registered write port.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int XLEN       = regfile_write_arbiter_pkg::XLEN,
  parameter int REG_ADDR_W = regfile_write_arbiter_pkg::REG_ADDR_W,
  localparam int NUM_REGS  = 2 ** REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic [REG_ADDR_W-1:0] req0_reg,
  input  logic [REG_ADDR_W-1:0] req1_reg,
  input  logic [XLEN-1:0]       req0_data,
  input  logic [XLEN-1:0]       req1_data,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [XLEN-1:0]       write_data,
  output logic [NUM_REGS-1:0]   pending_mask
);

  logic [1:0]            req_valid;
  logic [REG_ADDR_W-1:0] req_reg   [2];
  logic [XLEN-1:0]       req_data  [2];

  logic [1:0]            slot_valid, slot_age, slot_fill, slot_ready;
  logic [1:0]            slot_grant, slot_remains;
  logic [REG_ADDR_W-1:0] slot_reg  [2];
  logic [XLEN-1:0]       slot_data [2];

  grant_e                grant_sel;
  logic                  tie;
  logic                  rr_q, rr_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [XLEN-1:0]       write_data_q, write_data_d;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_reg[0]  = req0_reg;
  assign req_reg[1]  = req1_reg;
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      regfile_wb_slot #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
      ) u_slot (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (req_valid[gi]),
        .in_reg        (req_reg[gi]),
        .in_data       (req_data[gi]),
        .grant         (slot_grant[gi]),
        .other_remains (slot_remains[1-gi]),
        .other_fill    (slot_fill[1-gi]),
        .ready         (slot_ready[gi]),
        .fill          (slot_fill[gi]),
        .valid         (slot_valid[gi]),
        .slot_reg      (slot_reg[gi]),
        .slot_data     (slot_data[gi]),
        .age           (slot_age[gi])
      );
    end
  endgenerate

  assign req0_ready = slot_ready[0];
  assign req1_ready = slot_ready[1];

  // Pick one slot: older entry first; equal age is a tie for the pointer,
  // except that same-destination ties always drain requester 0 first.
  always_comb begin
    grant_sel = GRANT_NONE;
    tie       = 1'b0;
    if (&slot_valid) begin
      if (slot_age[0] && !slot_age[1]) begin
        grant_sel = GRANT_REQ1;
      end else if (slot_age[1] && !slot_age[0]) begin
        grant_sel = GRANT_REQ0;
      end else begin
        tie = 1'b1;
        if (slot_reg[0] == slot_reg[1]) begin
          grant_sel = GRANT_REQ0;
        end else begin
          grant_sel = rr_q ? GRANT_REQ1 : GRANT_REQ0;
        end
      end
    end else if (slot_valid[0]) begin
      grant_sel = GRANT_REQ0;
    end else if (slot_valid[1]) begin
      grant_sel = GRANT_REQ1;
    end
  end

  assign slot_grant   = {grant_sel == GRANT_REQ1, grant_sel == GRANT_REQ0};
  assign slot_remains = slot_valid & ~slot_grant;

  // Next write-port contents and pointer; the port holds when idle and the
  // pointer advances on every tie, including same-destination ones.
  always_comb begin
    rr_d         = rr_q ^ tie;
    reg_write_d  = (grant_sel != GRANT_NONE);
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    case (grant_sel)
      GRANT_REQ0: begin
        write_reg_d  = slot_reg[0];
        write_data_d = slot_data[0];
      end
      GRANT_REQ1: begin
        write_reg_d  = slot_reg[1];
        write_data_d = slot_data[1];
      end
      default: begin
      end
    endcase
  end

  // Write port and round-robin pointer; reset drops any in-flight write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q         <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      rr_q         <= rr_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

  // Registers with a write held in a slot or on the write port; x0 never.
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_pending
      if (gi == 0) begin : g_x0
        assign pending_mask[gi] = 1'b0;
      end else begin : g_rn
        localparam logic [REG_ADDR_W-1:0] IDX = REG_ADDR_W'(gi);
        assign pending_mask[gi] = (slot_valid[0] && (slot_reg[0] == IDX)) ||
                                  (slot_valid[1] && (slot_reg[1] == IDX)) ||
                                  (reg_write_q && (write_reg_q == IDX));
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: timestamp-ordered reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_reg, req1_reg, write_reg;
  logic [31:0] req0_data, req1_data, write_data, pending_mask;
  logic        reg_write;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req0_valid   (req0_valid),
    .req1_valid   (req1_valid),
    .req0_ready   (req0_ready),
    .req1_ready   (req1_ready),
    .req0_reg     (req0_reg),
    .req1_reg     (req1_reg),
    .req0_data    (req0_data),
    .req1_data    (req1_data),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .pending_mask (pending_mask)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: each held write carries the cycle it was accepted in.
  logic        mv    [2];
  logic [4:0]  mreg  [2];
  logic [31:0] mdata [2];
  int          mts   [2];
  logic        mrr;
  logic        mwe;
  logic [4:0]  mwr;
  logic [31:0] mwd;
  int          mcyc;

  function automatic bit m_tie();
    return mv[0] && mv[1] && (mts[0] == mts[1]);
  endfunction

  function automatic int m_grant();
    if (mv[0] && mv[1]) begin
      if (mts[0] < mts[1]) return 0;
      if (mts[1] < mts[0]) return 1;
      if (mreg[0] == mreg[1]) return 0;
      return mrr ? 1 : 0;
    end
    if (mv[0]) return 0;
    if (mv[1]) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] m = '0;
    for (int k = 0; k < 2; k++) if (mv[k]) m[mreg[k]] = 1'b1;
    if (mwe) m[mwr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        mv[k]    <= 1'b0;
        mreg[k]  <= '0;
        mdata[k] <= '0;
        mts[k]   <= 0;
      end
      mrr  <= 1'b0;
      mwe  <= 1'b0;
      mwr  <= '0;
      mwd  <= '0;
      mcyc <= 0;
    end else begin
      mwe <= (m_grant() >= 0);
      if (m_grant() >= 0) begin
        mwr <= (m_grant() == 1) ? mreg[1] : mreg[0];
        mwd <= (m_grant() == 1) ? mdata[1] : mdata[0];
      end
      if (m_tie()) mrr <= ~mrr;
      for (int k = 0; k < 2; k++) begin
        if (mv[k] && m_grant() != k) begin
          // stalled: contents unchanged
        end else if ((k == 0 ? req0_valid : req1_valid) &&
                     ((k == 0 ? req0_reg : req1_reg) != '0)) begin
          mv[k]    <= 1'b1;
          mreg[k]  <= (k == 0) ? req0_reg : req1_reg;
          mdata[k] <= (k == 0) ? req0_data : req1_data;
          mts[k]   <= mcyc;
        end else begin
          mv[k] <= 1'b0;
        end
      end
      mcyc <= mcyc + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("model_ready0", req0_ready, !mv[0] || (m_grant() == 0));
      chk1("model_ready1", req1_ready, !mv[1] || (m_grant() == 1));
      chk1("model_reg_write", reg_write, mwe);
      chk("model_write_reg", 32'(write_reg), 32'(mwr));
      chk("model_write_data", write_data, mwd);
      chk("model_pending", pending_mask, m_pending());
      if (reg_write) $display("t=%0t write x%0d <= 0x%08h", $time, write_reg, write_data);
    end
  end

  task automatic step(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  logic prev_src, cur_src;

  initial begin
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
    req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);
    chk1("rst_reg_write", reg_write, 1'b0);
    chk("rst_pending", pending_mask, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk1("post_rst_ready0", req0_ready, 1'b1);
    chk1("post_rst_ready1", req1_ready, 1'b1);
    chk_en = 1'b1;

    // single request, two-cycle latency
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk1("single_pend_held", pending_mask[5], 1'b1);
    chk1("single_no_write_yet", reg_write, 1'b0);
    idle();
    chk1("single_we", reg_write, 1'b1);
    chk("single_reg", 32'(write_reg), 32'd5);
    chk("single_data", write_data, 32'hDEADBEEF);
    chk1("single_pend_port", pending_mask[5], 1'b1);
    idle();
    chk1("single_we_drop", reg_write, 1'b0);
    chk("single_pend_clear", pending_mask, 32'h0);

    // simultaneous distinct, then repeated tie
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    idle();
    chk("tie1_first_reg", 32'(write_reg), 32'd3);
    chk("tie1_first_data", write_data, 32'h11);
    idle();
    chk("tie1_second_reg", 32'(write_reg), 32'd4);
    chk("tie1_second_data", write_data, 32'h22);
    idle();
    chk1("tie1_idle", reg_write, 1'b0);
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    idle();
    chk("tie2_first_reg", 32'(write_reg), 32'd4);
    idle();
    chk("tie2_second_reg", 32'(write_reg), 32'd3);
    idle();

    // simultaneous same destination: requester 1 lands last
    step(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB);
    idle();
    chk("same_first_data", write_data, 32'hAA);
    chk1("same_pend7", pending_mask[7], 1'b1);
    idle();
    chk("same_second_data", write_data, 32'hBB);
    idle();
    chk1("same_idle", reg_write, 1'b0);
    chk1("same_pend7_final", pending_mask[7], 1'b0);

    // x0 filter
    chk1("x0_ready1", req1_ready, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    chk1("x0_no_write_a", reg_write, 1'b0);
    chk("x0_pend_a", pending_mask, 32'h0);
    idle();
    chk1("x0_no_write_b", reg_write, 1'b0);
    chk("x0_pend_b", pending_mask, 32'h0);

    // continuous back-pressure from both requesters
    prev_src = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'(1 + i), 32'h100 + 32'(i), 1'b1, 5'(20 + i), 32'h200 + 32'(i));
      chk1("bp_one_ready", req0_ready ^ req1_ready, 1'b1);
      if (i >= 1) begin
        chk1("bp_we", reg_write, 1'b1);
        cur_src = write_data[9];
        if (i >= 2) chk1("bp_alternate", cur_src, ~prev_src);
        prev_src = cur_src;
      end
    end
    idle();
    idle();
    idle();
    chk1("bp_drained", reg_write, 1'b0);
    chk("bp_pend_clear", pending_mask, 32'h0);

    // asynchronous reset with both slots full and a write on the port
    step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'h1010);
    step(1'b1, 5'd11, 32'h1111, 1'b1, 5'd12, 32'h1212);
    chk1("prerst_we", reg_write, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk1("midrst_we", reg_write, 1'b0);
    chk("midrst_pend", pending_mask, 32'h0);
    chk("midrst_wreg", 32'(write_reg), 32'h0);
    chk("midrst_wdata", write_data, 32'h0);
    chk1("midrst_ready0", req0_ready, 1'b0);
    chk1("midrst_ready1", req1_ready, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk1("release_ready0", req0_ready, 1'b1);
    chk1("release_ready1", req1_ready, 1'b1);
    chk1("release_we", reg_write, 1'b0);
    chk_en = 1'b1;
    idle();
    chk1("release_no_write_a", reg_write, 1'b0);
    chk("release_pend_a", pending_mask, 32'h0);
    idle();
    chk1("release_no_write_b", reg_write, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
